// File: rtl/i4002x_pkg.sv
// Shared types and constants for the i4002x RAM/output-port chip.
package i4002x_pkg;

    typedef enum logic [2:0] {
        PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
    } phase_e;

    localparam logic [3:0] OP_WRM = 4'h0;
    localparam logic [3:0] OP_WMP = 4'h1;
    localparam logic [3:0] OP_WRR = 4'h2;
    localparam logic [3:0] OP_WPM = 4'h3;
    localparam logic [3:0] OP_WR0 = 4'h4;
    localparam logic [3:0] OP_WR1 = 4'h5;
    localparam logic [3:0] OP_WR2 = 4'h6;
    localparam logic [3:0] OP_WR3 = 4'h7;
    localparam logic [3:0] OP_SBM = 4'h8;
    localparam logic [3:0] OP_RDM = 4'h9;
    localparam logic [3:0] OP_RDR = 4'hA;
    localparam logic [3:0] OP_ADM = 4'hB;
    localparam logic [3:0] OP_RD0 = 4'hC;
    localparam logic [3:0] OP_RD1 = 4'hD;
    localparam logic [3:0] OP_RD2 = 4'hE;
    localparam logic [3:0] OP_RD3 = 4'hF;

    // Each register owns CHARS main nibbles followed by STATUS status nibbles.
    function automatic int flatAddr(input int regIdx, input int idx,
                                    input int chars, input int status);
        return regIdx * (chars + status) + idx;
    endfunction

endpackage

// File: rtl/i4002x_phase_ctr.sv
// Bus phase tracker: advances once per STEP, resynchronised to A1 by SYNC.
module i4002x_phase_ctr
    import i4002x_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_step,
    input  logic i_sync,
    output logic o_stbM2,
    output logic o_stbX2,
    output logic o_stbX3
);

    phase_e r_phase;
    phase_e w_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= PH_A1;
        end else begin
            r_phase <= w_next;
        end
    end

    // SYNC marks the completing phase as X3, so the next one is always A1.
    always_comb begin
        w_next = r_phase;
        if (i_step) begin
            if (i_sync) begin
                w_next = PH_A1;
            end else begin
                w_next = phase_e'(r_phase + 3'd1);
            end
        end
    end

    assign o_stbM2 = (r_phase == PH_M2);
    assign o_stbX2 = (r_phase == PH_X2);
    assign o_stbX3 = (r_phase == PH_X3);

endmodule

// File: rtl/i4002x_ram.sv
// 4002-style RAM chip: SRC/IO decode, nibble storage, output port, clear engine.
module i4002x_ram
    import i4002x_pkg::*;
#(
    parameter logic CHIP_SEL = 1'b0,
    parameter int   REGS     = 4,
    parameter int   CHARS    = 16,
    parameter int   STATUS   = 4,
    parameter int   OUT_W    = 4
) (
    input  logic             clk_i,
    input  logic             RESET_N_i,
    input  logic             STEP_i,
    input  logic             SYNC_i,
    input  logic [3:0]       D_i,
    output logic [3:0]       D_o,
    output logic             D_oe_o,
    input  logic             CM_i,
    input  logic             P0_i,
    output logic [OUT_W-1:0] O_o,
    output logic             busy_o
);

    localparam int TOTAL = REGS * (CHARS + STATUS);
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic             w_stbM2;
    logic             w_stbX2;
    logic             w_stbX3;
    logic             r_selected;
    logic [1:0]       r_reg;
    logic [3:0]       r_char;
    logic [3:0]       r_op;
    logic             r_opValid;
    logic             r_srcPend;
    logic [OUT_W-1:0] r_out;
    logic             r_busy;
    logic [AW-1:0]    r_clrAddr;
    logic [3:0]       r_mem [0:TOTAL-1];

    logic             w_chipHit;
    logic             w_isStatus;
    logic             w_isMainRd;
    logic             w_isRead;
    logic             w_isWrite;
    logic             w_addrOk;
    int               w_index;
    logic [AW-1:0]    w_addr;
    logic [3:0]       w_rdData;
    logic             w_memWe;

    i4002x_phase_ctr u_phase (
        .i_clk   (clk_i),
        .i_rst_n (RESET_N_i),
        .i_step  (STEP_i),
        .i_sync  (SYNC_i),
        .o_stbM2 (w_stbM2),
        .o_stbX2 (w_stbX2),
        .o_stbX3 (w_stbX3)
    );

    assign w_chipHit = (D_i[3] == CHIP_SEL) && (D_i[2] == P0_i);

    // SRC captures at X2/X3; IO opcode is latched at M2 and lives until X3.
    always_ff @(posedge clk_i or negedge RESET_N_i) begin
        if (!RESET_N_i) begin
            r_selected <= 1'b0;
            r_reg      <= 2'd0;
            r_char     <= 4'd0;
            r_op       <= OP_WRM;
            r_opValid  <= 1'b0;
            r_srcPend  <= 1'b0;
            r_out      <= '0;
        end else if (STEP_i) begin
            if (w_stbM2) begin
                r_op      <= D_i;
                r_opValid <= CM_i && r_selected;
            end else if (w_stbX3 || SYNC_i) begin
                r_opValid <= 1'b0;
            end
            if (w_stbX2 && CM_i) begin
                r_selected <= w_chipHit;
                r_reg      <= D_i[1:0];
                r_srcPend  <= 1'b1;
            end else if (w_stbX3 || SYNC_i) begin
                r_srcPend <= 1'b0;
                if (w_stbX3 && r_srcPend && r_selected) begin
                    r_char <= D_i;
                end
            end
            if (w_stbX2 && r_opValid && (r_op == OP_WMP)) begin
                r_out <= D_i[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge RESET_N_i) begin
        if (!RESET_N_i) begin
            r_busy    <= 1'b1;
            r_clrAddr <= '0;
        end else if (r_busy) begin
            if (r_clrAddr == AW'(TOTAL - 1)) begin
                r_busy <= 1'b0;
            end else begin
                r_clrAddr <= r_clrAddr + AW'(1);
            end
        end
    end

    always_comb begin
        w_isStatus = 1'b0;
        w_isMainRd = 1'b0;
        w_isWrite  = 1'b0;
        w_addrOk   = 1'b0;
        w_index    = 0;
        w_isStatus = (r_op[3:2] == 2'b01) || (r_op[3:2] == 2'b11);
        w_isMainRd = (r_op == OP_RDM) || (r_op == OP_SBM) || (r_op == OP_ADM);
        w_isWrite  = (r_op == OP_WRM) || (r_op[3:2] == 2'b01);
        if (w_isStatus) begin
            w_index  = CHARS + int'(r_op[1:0]);
            w_addrOk = (int'(r_reg) < REGS) && (int'(r_op[1:0]) < STATUS);
        end else begin
            w_index  = int'(r_char);
            w_addrOk = (int'(r_reg) < REGS) && (int'(r_char) < CHARS);
        end
    end

    assign w_isRead = r_opValid && (w_isMainRd || (r_op[3:2] == 2'b11));
    assign w_addr   = AW'(flatAddr(int'(r_reg), w_index, CHARS, STATUS));
    assign w_rdData = (w_addrOk && !r_busy) ? r_mem[w_addr] : 4'h0;
    assign w_memWe  = STEP_i && w_stbX2 && r_opValid && w_isWrite && w_addrOk;

    // The clear engine owns the write port while busy; bus writes are dropped.
    always_ff @(posedge clk_i) begin
        if (r_busy) begin
            r_mem[r_clrAddr] <= 4'h0;
        end else if (w_memWe) begin
            r_mem[w_addr] <= D_i;
        end
    end

    assign D_oe_o = w_isRead && w_stbX2;
    assign D_o    = D_oe_o ? w_rdData : 4'h0;
    assign O_o    = r_out;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_i4002x_ram.sv
// Directed bench for i4002x_ram: two instances (default-ish and STATUS=2) share one bus.
module tb_i4002x_ram;

    logic       clk = 1'b0;
    logic       rstN;
    logic       step;
    logic       sync;
    logic       cmI;
    logic       p0;
    logic [3:0] dI;

    logic [3:0] doA;
    logic       oeA;
    logic [2:0] oA;
    logic       busyA;
    logic [3:0] doB;
    logic       oeB;
    logic [3:0] oB;
    logic       busyB;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] oeMaskA;
    logic [7:0] oeMaskB;
    logic [3:0] x2DoA;
    logic [3:0] x2DoB;

    always #5 clk = ~clk;

    i4002x_ram #(.CHIP_SEL(1'b0), .REGS(4), .CHARS(16), .STATUS(4), .OUT_W(3)) dutA (
        .clk_i(clk), .RESET_N_i(rstN), .STEP_i(step), .SYNC_i(sync), .D_i(dI),
        .D_o(doA), .D_oe_o(oeA), .CM_i(cmI), .P0_i(p0), .O_o(oA), .busy_o(busyA)
    );

    i4002x_ram #(.CHIP_SEL(1'b0), .REGS(4), .CHARS(16), .STATUS(2), .OUT_W(4)) dutB (
        .clk_i(clk), .RESET_N_i(rstN), .STEP_i(step), .SYNC_i(sync), .D_i(dI),
        .D_o(doB), .D_oe_o(oeB), .CM_i(cmI), .P0_i(p0), .O_o(oB), .busy_o(busyB)
    );

    typedef struct {
        string      name;
        logic [3:0] m2D;
        logic       m2Cm;
        logic [3:0] x2D;
        logic       x2Cm;
        logic [3:0] x3D;
        logic [7:0] expOeA;
        logic [3:0] expDoA;
        logic [2:0] expOA;
        logic [7:0] expOeB;
        logic [3:0] expDoB;
    } vec_t;

    localparam logic [7:0] NO  = 8'h00;
    localparam logic [7:0] X2M = 8'h40;

    vec_t vecs [24];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One full 8-phase instruction cycle; starts and ends at posedge+1 with phase A1.
    task automatic applyStimulus(input logic [3:0] m2D, input logic m2Cm,
                                 input logic [3:0] x2D, input logic x2Cm,
                                 input logic [3:0] x3D);
        oeMaskA = 8'h00;
        oeMaskB = 8'h00;
        x2DoA   = 4'h0;
        x2DoB   = 4'h0;
        for (int p = 0; p < 8; p++) begin
            dI   = (p == 4) ? m2D : (p == 6) ? x2D : (p == 7) ? x3D : 4'h0;
            cmI  = (p == 4) ? m2Cm : (p == 6) ? x2Cm : 1'b0;
            sync = (p == 7);
            step = 1'b1;
            #1;
            oeMaskA[p] = oeA;
            oeMaskB[p] = oeB;
            if (p == 6) begin
                x2DoA = doA;
                x2DoB = doB;
            end
            @(posedge clk);
            #1;
        end
        step = 1'b0;
        sync = 1'b0;
        cmI  = 1'b0;
        dI   = 4'h0;
    endtask

    task automatic countBusy(input string tag);
        int nA = 0;
        int nB = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (!busyA && nA == 0) nA = c;
            if (!busyB && nB == 0) nB = c;
            if (nA != 0 && nB != 0) break;
        end
        checkOutput({tag, "_busyCyclesA"}, nA, 80);
        checkOutput({tag, "_busyCyclesB"}, nB, 72);
    endtask

    task automatic stepOne(input logic [3:0] d, input logic s);
        dI   = d;
        cmI  = 1'b0;
        sync = s;
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        sync = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"src25",    4'h0, 1'b0, 4'h2, 1'b1, 4'h5, NO,  4'h0, 3'd0, NO,  4'h0};
        vecs[1]  = '{"rdmFresh", 4'h9, 1'b1, 4'h0, 1'b0, 4'h0, X2M, 4'h0, 3'd0, X2M, 4'h0};
        vecs[2]  = '{"wrmA",     4'h0, 1'b1, 4'hA, 1'b0, 4'h0, NO,  4'h0, 3'd0, NO,  4'h0};
        vecs[3]  = '{"src25b",   4'h0, 1'b0, 4'h2, 1'b1, 4'h5, NO,  4'h0, 3'd0, NO,  4'h0};
        vecs[4]  = '{"rdmA",     4'h9, 1'b1, 4'h0, 1'b0, 4'h0, X2M, 4'hA, 3'd0, X2M, 4'hA};
        vecs[5]  = '{"wmp6",     4'h1, 1'b1, 4'h6, 1'b0, 4'h0, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[6]  = '{"rdmKeepO", 4'h9, 1'b1, 4'h0, 1'b0, 4'h0, X2M, 4'hA, 3'd6, X2M, 4'hA};
        vecs[7]  = '{"srcDesel", 4'h0, 1'b0, 4'h4, 1'b1, 4'h5, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[8]  = '{"wrmDesel", 4'h0, 1'b1, 4'hF, 1'b0, 4'h0, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[9]  = '{"rdmDesel", 4'h9, 1'b1, 4'h0, 1'b0, 4'h0, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[10] = '{"src25c",   4'h0, 1'b0, 4'h2, 1'b1, 4'h5, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[11] = '{"rdmOld",   4'h9, 1'b1, 4'h0, 1'b0, 4'h0, X2M, 4'hA, 3'd6, X2M, 4'hA};
        vecs[12] = '{"src10",    4'h0, 1'b0, 4'h1, 1'b1, 4'h0, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[13] = '{"wr3",      4'h7, 1'b1, 4'h9, 1'b0, 4'h0, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[14] = '{"rd3",      4'hF, 1'b1, 4'h0, 1'b0, 4'h0, X2M, 4'h9, 3'd6, X2M, 4'h0};
        vecs[15] = '{"wr1",      4'h5, 1'b1, 4'h9, 1'b0, 4'h0, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[16] = '{"rd1",      4'hD, 1'b1, 4'h0, 1'b0, 4'h0, X2M, 4'h9, 3'd6, X2M, 4'h9};
        vecs[17] = '{"wrrIgn",   4'h2, 1'b1, 4'h3, 1'b0, 4'h0, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[18] = '{"rdrIgn",   4'hA, 1'b1, 4'h0, 1'b0, 4'h0, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[19] = '{"wpmIgn",   4'h3, 1'b1, 4'h5, 1'b0, 4'h0, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[20] = '{"src25d",   4'h0, 1'b0, 4'h2, 1'b1, 4'h5, NO,  4'h0, 3'd6, NO,  4'h0};
        vecs[21] = '{"sbm",      4'h8, 1'b1, 4'h0, 1'b0, 4'h0, X2M, 4'hA, 3'd6, X2M, 4'hA};
        vecs[22] = '{"wmp1",     4'h1, 1'b1, 4'h1, 1'b0, 4'h0, NO,  4'h0, 3'd1, NO,  4'h0};
        vecs[23] = '{"rd0Zero",  4'hC, 1'b1, 4'h0, 1'b0, 4'h0, X2M, 4'h0, 3'd1, X2M, 4'h0};

        rstN = 1'b0;
        step = 1'b0;
        sync = 1'b0;
        cmI  = 1'b0;
        p0   = 1'b0;
        dI   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusyA", busyA, 1);
        checkOutput("rstBusyB", busyB, 1);
        checkOutput("rstOeA", oeA, 0);
        checkOutput("rstDoA", doA, 0);
        checkOutput("rstOA", oA, 0);

        rstN = 1'b1;
        countBusy("initClear");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].m2D, vecs[i].m2Cm, vecs[i].x2D, vecs[i].x2Cm, vecs[i].x3D);
            checkOutput({vecs[i].name, "_oeA"}, oeMaskA, vecs[i].expOeA);
            checkOutput({vecs[i].name, "_doA"}, x2DoA, vecs[i].expDoA);
            checkOutput({vecs[i].name, "_oA"}, oA, vecs[i].expOA);
            checkOutput({vecs[i].name, "_oeB"}, oeMaskB, vecs[i].expOeB);
            checkOutput({vecs[i].name, "_doB"}, x2DoB, vecs[i].expDoB);
        end

        // Reset arriving in the middle of a WMP instruction, during M2.
        for (int p = 0; p < 4; p++) stepOne(4'h0, 1'b0);
        dI   = 4'h1;
        cmI  = 1'b1;
        step = 1'b1;
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("midRst_oA", oA, 0);
        checkOutput("midRst_busyA", busyA, 1);
        checkOutput("midRst_oeA", oeA, 0);
        step = 1'b0;
        cmI  = 1'b0;
        dI   = 4'h0;
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Second reset pulse while the clear engine is halfway through.
        repeat (30) @(posedge clk);
        #1;
        checkOutput("midClear_busyA", busyA, 1);
        rstN = 1'b0;
        #2;
        rstN = 1'b1;
        countBusy("restartClear");

        // SYNC on the A2 step must pull the phase back to A1.
        stepOne(4'h0, 1'b0);
        stepOne(4'h0, 1'b1);
        applyStimulus(4'h0, 1'b0, 4'h2, 1'b1, 4'h5);
        applyStimulus(4'h0, 1'b1, 4'h3, 1'b0, 4'h0);
        applyStimulus(4'h0, 1'b0, 4'h2, 1'b1, 4'h5);
        applyStimulus(4'h9, 1'b1, 4'h0, 1'b0, 4'h0);
        checkOutput("syncRealign_oeA", oeMaskA, X2M);
        checkOutput("syncRealign_doA", x2DoA, 4'h3);
        checkOutput("syncRealign_doB", x2DoB, 4'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
